// File: rtl/pulse_stretch_pkg.sv
// Shared encodings for the pulse/timing blocks: operating modes and the
// monostable FSM states, plus a helper sizing the hold-off counter.
package pulse_stretch_pkg;

  localparam int MODE_ONESHOT = 0;
  localparam int MODE_RETRIG  = 1;
  localparam int MODE_TOGGLE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } ps_state_e;

  // A zero hold-off still needs a 1-bit counter to keep the vector legal.
  function automatic int hold_width(input int holdoff);
    return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretch_trig_qualify.sv
// Trigger qualifier: passes trig through as a level trigger, or reduces it to
// a single-cycle rising-edge strobe using a one-cycle delayed copy.
module trig_qualify #(
  parameter int TRIG_EDGE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic qtrig
);

  logic trig_d;

  // Cleared in reset so a trig held high across reset release fires once.
  always_ff @(posedge clk) begin
    if (rst) trig_d <= 1'b0;
    else     trig_d <= trig;
  end

  assign qtrig = (TRIG_EDGE != 0) ? (trig & ~trig_d) : trig;

endmodule

// File: rtl/pulse_stretch.sv
// Monostable pulse stretcher: one-shot, retriggerable or toggle operation with
// an optional hold-off gap after each pulse. All outputs are registered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a qualified trigger
// ST_ACTIVE  | dout high, cnt counting down the remaining high cycles
// ST_HOLDOFF | dout low, hold counting down; triggers ignored (overrun)
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int MODE      = 0,
  parameter int TRIG_EDGE = 1,
  parameter int CNT_W     = 16,
  parameter int HOLDOFF   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int                HOLD_W     = hold_width(HOLDOFF);
  localparam bit                HAS_HOLD   = (HOLDOFF > 0);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLDOFF);
  localparam bit                IS_ONESHOT = (MODE == MODE_ONESHOT);
  localparam bit                IS_RETRIG  = (MODE == MODE_RETRIG);
  localparam bit                IS_TOGGLE  = (MODE == MODE_TOGGLE);

  ps_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, leff;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              qtrig;
  logic              in_active, cnt_last, hold_last;
  logic              retrig, chain, ignored;
  logic              dout_nxt, busy_nxt, done_nxt, overrun_nxt;

  trig_qualify #(.TRIG_EDGE(TRIG_EDGE)) u_qual (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .qtrig(qtrig)
  );

  assign leff      = (len == '0) ? CNT_W'(1) : len;
  assign in_active = (state == ST_ACTIVE);
  assign cnt_last  = (cnt <= CNT_W'(1));
  assign hold_last = (hold <= HOLD_W'(1));

  // A one-shot without hold-off may chain a new pulse off its final cycle.
  assign retrig  = IS_RETRIG && in_active && qtrig;
  assign chain   = IS_ONESHOT && !HAS_HOLD && in_active && cnt_last && qtrig;
  assign ignored = qtrig && ((state == ST_HOLDOFF) ||
                             (IS_ONESHOT && in_active && !chain));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hold    <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hold    <= hold_nxt;
      dout    <= dout_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      overrun <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    case (state)
      ST_IDLE: begin
        if (qtrig) begin
          if (IS_TOGGLE) begin
            if (HAS_HOLD) begin
              state_nxt = ST_HOLDOFF;
              hold_nxt  = HOLD_LOAD;
            end
          end else begin
            state_nxt = ST_ACTIVE;
            cnt_nxt   = leff;
          end
        end
      end
      ST_ACTIVE: begin
        if (retrig || chain) begin
          cnt_nxt = leff;
        end else if (cnt_last) begin
          cnt_nxt = '0;
          if (HAS_HOLD) begin
            state_nxt = ST_HOLDOFF;
            hold_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (hold_last) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold - HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    dout_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;
    if (IS_TOGGLE) dout_nxt = dout ^ ((state == ST_IDLE) && qtrig);
    else           dout_nxt = (state_nxt == ST_ACTIVE);
    busy_nxt    = (state_nxt != ST_IDLE);
    done_nxt    = !IS_TOGGLE && in_active && cnt_last && !retrig;
    overrun_nxt = ignored;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: seven parameter variants share one stimulus stream
// and are compared every cycle with a remaining-cycles model.
module tb_pulse_stretch;

  localparam int NI = 7;
  localparam int MODE_C [NI] = '{0, 1, 0, 2, 0, 1, 2};
  localparam int TE_C   [NI] = '{1, 1, 0, 1, 1, 0, 0};
  localparam int HO_C   [NI] = '{0, 0, 3, 0, 0, 2, 2};
  localparam int CW_C   [NI] = '{16, 16, 16, 16, 4, 16, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic [15:0]   len = '0;
  logic [NI-1:0] dout_v, busy_v, done_v, ovr_v;

  pulse_stretch #(.MODE(0), .TRIG_EDGE(1), .CNT_W(16), .HOLDOFF(0)) u0 (.clk(clk), .rst(rst), .trig(trig), .len(len),
    .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .overrun(ovr_v[0]));
  pulse_stretch #(.MODE(1), .TRIG_EDGE(1), .CNT_W(16), .HOLDOFF(0)) u1 (.clk(clk), .rst(rst), .trig(trig), .len(len),
    .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .overrun(ovr_v[1]));
  pulse_stretch #(.MODE(0), .TRIG_EDGE(0), .CNT_W(16), .HOLDOFF(3)) u2 (.clk(clk), .rst(rst), .trig(trig), .len(len),
    .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]), .overrun(ovr_v[2]));
  pulse_stretch #(.MODE(2), .TRIG_EDGE(1), .CNT_W(16), .HOLDOFF(0)) u3 (.clk(clk), .rst(rst), .trig(trig), .len(len),
    .dout(dout_v[3]), .busy(busy_v[3]), .done(done_v[3]), .overrun(ovr_v[3]));
  pulse_stretch #(.MODE(0), .TRIG_EDGE(1), .CNT_W(4), .HOLDOFF(0)) u4 (.clk(clk), .rst(rst), .trig(trig), .len(len[3:0]),
    .dout(dout_v[4]), .busy(busy_v[4]), .done(done_v[4]), .overrun(ovr_v[4]));
  pulse_stretch #(.MODE(1), .TRIG_EDGE(0), .CNT_W(16), .HOLDOFF(2)) u5 (.clk(clk), .rst(rst), .trig(trig), .len(len),
    .dout(dout_v[5]), .busy(busy_v[5]), .done(done_v[5]), .overrun(ovr_v[5]));
  pulse_stretch #(.MODE(2), .TRIG_EDGE(0), .CNT_W(16), .HOLDOFF(2)) u6 (.clk(clk), .rst(rst), .trig(trig), .len(len),
    .dout(dout_v[6]), .busy(busy_v[6]), .done(done_v[6]), .overrun(ovr_v[6]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: remaining high cycles / hold-off cycles counted from the current cycle.
  int   m_high [NI];
  int   m_hold [NI];
  bit   m_lvl  [NI];
  bit   m_done [NI];
  bit   m_ovr  [NI];
  bit   m_prev = 1'b0;
  logic h [NI][4][64];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit t, input int l, input bit r);
    bit q, nd, no;
    int lv, leff;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.dout@%0d", i, cyc), dout_v[i], (MODE_C[i] == 2) ? m_lvl[i] : (m_high[i] > 0));
      chk($sformatf("u%0d.busy@%0d", i, cyc), busy_v[i], (m_high[i] > 0) || (m_hold[i] > 0));
      chk($sformatf("u%0d.done@%0d", i, cyc), done_v[i], m_done[i]);
      chk($sformatf("u%0d.overrun@%0d", i, cyc), ovr_v[i], m_ovr[i]);
      if (cyc < 64) begin
        h[i][0][cyc] = dout_v[i];
        h[i][1][cyc] = busy_v[i];
        h[i][2][cyc] = done_v[i];
        h[i][3][cyc] = ovr_v[i];
      end
    end
    trig = t;
    len  = 16'(l);
    rst  = r;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_high[i] = 0; m_hold[i] = 0; m_lvl[i] = 1'b0;
        m_done[i] = 1'b0; m_ovr[i] = 1'b0;
      end else begin
        q    = (TE_C[i] != 0) ? (t && !m_prev) : t;
        lv   = l % (1 << CW_C[i]);
        leff = (lv == 0) ? 1 : lv;
        nd   = 1'b0;
        no   = 1'b0;
        if (MODE_C[i] == 2) begin
          if (m_hold[i] == 0) begin
            if (q) begin m_lvl[i] = !m_lvl[i]; m_hold[i] = HO_C[i]; end
          end else begin
            no = q; m_hold[i]--;
          end
        end else if (m_high[i] == 0 && m_hold[i] == 0) begin
          if (q) m_high[i] = leff;
        end else if (m_high[i] > 0) begin
          if (q && MODE_C[i] == 1) m_high[i] = leff;
          else if (m_high[i] == 1) begin
            nd = 1'b1;
            if (q && HO_C[i] == 0) m_high[i] = leff;
            else begin m_high[i] = 0; m_hold[i] = HO_C[i]; no = q; end
          end else begin
            no = q; m_high[i]--;
          end
        end else begin
          no = q; m_hold[i]--;
        end
        m_done[i] = nd;
        m_ovr[i]  = no;
      end
    end
    m_prev = r ? 1'b0 : t;
    cyc++;
  endtask

  task automatic start_scn();
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);
    cyc = 0;
  endtask

  task automatic run(input logic [63:0] tmask, input int l, input int ncyc);
    for (int c = 0; c < ncyc; c++) cycle(tmask[c], l, 1'b0);
  endtask

  // Checks a recorded signal over [from,to] against a single high window [lo,hi].
  task automatic chk_win(input string name, input int inst, input int sig,
                         input int from, input int to, input int lo, input int hi);
    for (int c = from; c <= to; c++)
      chk($sformatf("%s@%0d", name, c), h[inst][sig][c], (c >= lo) && (c <= hi));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_high[i] = 0; m_hold[i] = 0; m_lvl[i] = 1'b0; m_done[i] = 1'b0; m_ovr[i] = 1'b0;
    end

    // Basic one-shot, len=5, trig at 10
    start_scn();
    run(64'h400, 5, 25);
    chk_win("basic_dout", 0, 0, 0, 24, 11, 15);
    chk_win("basic_busy", 0, 1, 0, 24, 11, 15);
    chk_win("basic_done", 0, 2, 0, 24, 16, 16);
    chk_win("basic_w4_dout", 4, 0, 0, 24, 11, 15);
    chk_win("basic_tog_done", 3, 2, 0, 24, 1, 0);

    // Retrigger: len=4, trigs at 10 and 12
    start_scn();
    run(64'h1400, 4, 25);
    chk_win("retrig_dout", 1, 0, 0, 24, 11, 16);
    chk_win("retrig_done", 1, 2, 0, 24, 17, 17);
    chk_win("retrig_ovr", 1, 3, 0, 24, 1, 0);
    chk_win("oneshot_dout", 0, 0, 0, 24, 11, 14);
    chk_win("oneshot_ovr", 0, 3, 0, 24, 13, 13);

    // Level triggers with hold-off: trig at 10, 11, 14, len=2
    start_scn();
    run(64'h4C00, 2, 22);
    chk_win("hold_dout", 2, 0, 0, 21, 11, 12);
    chk_win("hold_busy", 2, 1, 0, 21, 11, 15);
    chk_win("hold_done", 2, 2, 0, 21, 13, 13);
    chk_win("hold_ovr_a", 2, 3, 0, 14, 12, 12);
    chk_win("hold_ovr_b", 2, 3, 15, 21, 15, 15);

    // len=0 gives a single high cycle
    start_scn();
    run(64'h20, 0, 12);
    chk_win("len0_dout", 0, 0, 0, 11, 6, 6);
    chk_win("len0_w4_dout", 4, 0, 0, 11, 6, 6);
    chk_win("len0_done", 0, 2, 0, 11, 7, 7);

    // Back-to-back: len=3, second trig in the expiry cycle 13
    start_scn();
    run(64'h2400, 3, 22);
    chk_win("b2b_dout", 0, 0, 0, 21, 11, 16);
    chk_win("b2b_done_a", 0, 2, 0, 15, 14, 14);
    chk_win("b2b_done_b", 0, 2, 16, 21, 17, 17);
    chk_win("b2b_ovr", 0, 3, 0, 21, 1, 0);

    // Full-scale 4-bit length
    start_scn();
    run(64'h400, 15, 30);
    chk_win("max_w4_dout", 4, 0, 0, 29, 11, 25);
    chk_win("max_w4_done", 4, 2, 0, 29, 26, 26);

    // Toggle mode: trigs at 5 and 9
    start_scn();
    run(64'h220, 7, 16);
    chk_win("tog_dout", 3, 0, 0, 15, 6, 9);
    chk_win("tog_done", 3, 2, 0, 15, 1, 0);
    chk_win("tog_busy", 3, 1, 0, 15, 1, 0);

    // Reset in the third high cycle, then trig held high across reset release
    start_scn();
    for (int c = 0; c < 50; c++)
      cycle((c == 10) || (c >= 20), 8, (c == 13) || (c >= 20 && c <= 22));
    chk_win("rst_dout_a", 0, 0, 0, 19, 11, 13);
    chk_win("rst_dout_b", 0, 0, 20, 49, 24, 31);
    chk_win("rst_done", 0, 2, 0, 49, 32, 32);
    chk_win("rst_busy", 0, 1, 0, 19, 11, 13);

    // Randomized traffic across all variants
    start_scn();
    for (int n = 0; n < 2000; n++) begin
      int sel, l;
      bit t, r;
      t   = ($urandom_range(0, 99) < 35);
      sel = $urandom_range(0, 9);
      if (sel < 8)       l = $urandom_range(0, 6);
      else if (sel == 8) l = $urandom_range(14, 17);
      else               l = $urandom_range(0, 40);
      r = ($urandom_range(0, 199) == 0);
      cycle(t, l, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Monostable pulse generator: turns single-cycle strobes or rising edges into clean level pulses of a programmable cycle width.
- It is the counterpart of the edge-detector blocks. Those turn levels into strobes; this block turns strobes back into levels for LED, ADC-start, DAC-latch and display-strobe timing in the sample designs.
- Supports non-retriggerable, retriggerable and toggle operation, with an optional hold-off gap after each pulse.

Parameters:
- MODE, 0: 0 = non-retriggerable one-shot; 1 = retriggerable (re-arm extends the pulse); 2 = toggle (each trigger inverts dout).
- TRIG_EDGE, 1: 1 = trigger on the rising edge of trig; 0 = every cycle with trig high is a trigger.
- CNT_W, 16: width of the pulse-length counter and of len.
- HOLDOFF, 0: number of cycles after a pulse ends during which triggers are ignored. 0 = no hold-off.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  trigger input; must be synchronous to clk.
- len  in  CNT_W  pulse length in clk cycles; sampled when a trigger is accepted.
- dout  out  1  stretched pulse (modes 0/1) or toggled level (mode 2); registered.
- busy  out  1  high while in ACTIVE or HOLDOFF.
- done  out  1  one-cycle strobe in the cycle after the last high cycle of a pulse (modes 0/1 only).
- overrun  out  1  one-cycle strobe when a qualified trigger is ignored (mode 0 during ACTIVE; any mode during HOLDOFF).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: dout=0, busy=0, done=0, overrun=0, cnt=0, hold counter=0, trig_d=0, state=IDLE. rst is dominant over all other inputs.
- Trigger qualification: qtrig = trig & ~trig_d when TRIG_EDGE=1, otherwise qtrig = trig. trig_d is a 1-cycle register, so trig held high through reset release fires once.
- Effective length: leff = (len==0) ? 1 : len. All outputs are registered, so latency from trigger to output is 1 cycle.
- IDLE: qtrig in cycle N loads cnt=leff and sets dout=1, busy=1 from cycle N+1 -> ACTIVE.
- ACTIVE: dout stays high for exactly leff cycles. cnt decrements each cycle.
- At expiry (last high cycle): done=1 in the next cycle and dout=0.
  - If HOLDOFF>0: -> HOLDOFF.
  - If HOLDOFF=0: -> IDLE.
- Mode 0, qtrig during ACTIVE: ignored; overrun=1 next cycle.
- Mode 0, HOLDOFF=0, qtrig in the expiry cycle: accepted. The new pulse follows with no low gap, and done still strobes for the completed pulse.
- Mode 1, qtrig during ACTIVE (including the expiry cycle): reloads cnt=leff from the current len. dout stays high continuously and there is no done until the final expiry.
- HOLDOFF state: counts HOLDOFF cycles with busy=1 and dout=0. qtrig is ignored with overrun=1. Then -> IDLE.
- Mode 2: each qtrig inverts dout in the next cycle. len, done and cnt are unused. HOLDOFF applies after every toggle if nonzero; busy is high only during hold-off.
- len changes outside the accept cycle have no effect on a running pulse.
- Counter widths: cnt is CNT_W bits, so the maximum pulse is 2^CNT_W-1 cycles. The hold counter is $clog2(HOLDOFF+1) bits, minimum 1. There is no wrap: counters stop at terminal count.
- Reset mid-pulse: at the reset edge dout=0, busy=0 and no done is emitted.
- done and overrun never assert in the same cycle as rst.

Decomposition:
- Shared package: MODE encodings (MODE_ONESHOT=0, MODE_RETRIG=1, MODE_TOGGLE=2) and the FSM state encoding (IDLE, ACTIVE, HOLDOFF), for reuse by other timing blocks.
- Natural sub-module: trig_qualify. It holds the trig_d register and produces qtrig according to TRIG_EDGE.
- The FSM and counters stay in pulse_stretch.

Test Plan:
- Basic: MODE=0, TRIG_EDGE=1, len=5, 1-cycle trig at cycle 10 -> dout high cycles 11-15, done=1 at cycle 16, busy high cycles 11-15.
- Retrigger: MODE=1, len=4, trig pulses at cycles 10 and 12 -> dout high cycles 11-16 continuously, single done at cycle 17, overrun never asserted.
- Overrun and hold-off: MODE=0, HOLDOFF=3, len=2, trig at 10, 11 (level-mode, TRIG_EDGE=0) and 14.
  - dout high 11-12; overrun at 12 (trig 11 ignored) and at 15 (trig 14 falls in hold-off 13-15).
  - busy high 11-15.
- Boundaries: len=0 -> dout high exactly 1 cycle.
  - MODE=0, HOLDOFF=0, trig in expiry cycle -> back-to-back pulses with no low gap, done strobed between them.
  - CNT_W=4, len=15 -> dout high exactly 15 cycles.
- Toggle and reset: MODE=2, triggers at cycles 5 and 9 -> dout 1 from cycle 6, 0 from cycle 10, done never asserted.
  - MODE=0 len=8 with rst at the 3rd high cycle -> dout=0 next cycle, no done.
  - trig held high through rst release with TRIG_EDGE=1 -> exactly one pulse.
